shot_slot_scheduler: RTL and testbench

- Owns the four shot_status slots and decides when each one launches, lives and retires.
- Turns the fire key (j) into one-cycle launch grants, round-robin across idle slots, rate-limited by a frame-based cooldown.
- Counts each slot's lifetime in video frames and clears slots on hit.
- Drives withhold_shots (per-slot reset of shot_status) plus the shot counter (j_counter) shown on the hex display.

---
 rtl/shot_slot_scheduler.sv | 161 ++++++++++++++++
 tb/tb_shot_slot_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shot_slot_scheduler.sv
// Shot slot scheduler: owns the shot slots, grants launches round-robin under a frame cooldown,
// ages slots by video frame and retires them on expiry or hit. Optional autofire: SHOT_AUTOFIRE_EN.
module shot_slot_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int LIFETIME_FRAMES = 48,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int CNT_W           = 8,
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int AC_W  = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 Clk,
  input  logic                 Reset_h,
  input  logic                 vs,
  input  logic                 j,
  input  logic                 ship_alive,
  input  logic [NUM_SLOTS-1:0] hit_clear,
  output logic [NUM_SLOTS-1:0] withhold_shots,
  output logic                 launch_pulse,
  output logic [IDX_W-1:0]     launch_slot,
  output logic                 fire_dropped,
  output logic [3:0]           j_counter,
  output logic [AC_W-1:0]      active_count
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} slot_state_e;

  slot_state_e             state_q [NUM_SLOTS];
  slot_state_e             state_d [NUM_SLOTS];
  logic [CNT_W-1:0]        life_q  [NUM_SLOTS];
  logic [CNT_W-1:0]        life_d  [NUM_SLOTS];
  logic [CNT_W-1:0]        cool_q, cool_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        slot_q, slot_d;
  logic [3:0]              jcnt_q, jcnt_d;
  logic [AC_W-1:0]         acnt_q, acnt_d;
  logic                    launch_q, launch_d;
  logic                    drop_q, drop_d;
  logic                    vs_s1_q, vs_s2_q, vs_s3_q;
  logic                    j_q;
  logic                    frame_tick;
  logic                    fire_level;
  logic                    fire_rise;
  logic                    fire_req;
  logic                    found;
  logic [IDX_W-1:0]        winner;

  assign frame_tick = vs_s3_q & ~vs_s2_q;

`ifdef SHOT_AUTOFIRE_EN
  logic j_qq_q;
  always_ff @(posedge Clk) begin
    if (Reset_h) j_qq_q <= 1'b0;
    else         j_qq_q <= j_q;
  end
  assign fire_level = j_q;
  assign fire_rise  = j_q & ~j_qq_q;
`else
  assign fire_level = j & ~j_q;
  assign fire_rise  = fire_level;
`endif

  // Round-robin: first idle slot at or after the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!found && state_q[(int'(ptr_q) + k) % NUM_SLOTS] == S_IDLE) begin
        found  = 1'b1;
        winner = IDX_W'((int'(ptr_q) + k) % NUM_SLOTS);
      end
    end
  end

  assign fire_req = fire_level & ship_alive & (cool_q == '0) & found;

  always_comb begin
    acnt_d   = '0;
    launch_d = fire_req;
    drop_d   = fire_rise & ~fire_req;
    slot_d   = fire_req ? winner : slot_q;
    jcnt_d   = jcnt_q + 4'(fire_req);
    ptr_d    = fire_req ? IDX_W'((int'(winner) + 1) % NUM_SLOTS) : ptr_q;
    cool_d   = cool_q;
    if (fire_req)                       cool_d = CNT_W'(COOLDOWN_FRAMES);
    else if (frame_tick && cool_q != '0) cool_d = cool_q - CNT_W'(1);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      life_d[i]  = life_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (fire_req && winner == IDX_W'(i)) begin
            state_d[i] = S_ACTIVE;
            life_d[i]  = CNT_W'(LIFETIME_FRAMES);
          end
        end
        S_ACTIVE: begin
          // A hit and an expiry on the same cycle collapse into one retire.
          if (hit_clear[i] || (frame_tick && life_q[i] == CNT_W'(1))) begin
            state_d[i] = S_IDLE;
            life_d[i]  = '0;
          end else if (frame_tick) begin
            life_d[i] = life_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          life_d[i]  = '0;
        end
      endcase
      if (state_d[i] == S_ACTIVE) acnt_d = acnt_d + AC_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_s3_q  <= 1'b0;
      j_q      <= 1'b0;
      cool_q   <= '0;
      ptr_q    <= '0;
      slot_q   <= '0;
      jcnt_q   <= '0;
      acnt_q   <= '0;
      launch_q <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        life_q[i]  <= '0;
      end
    end else begin
      vs_s1_q  <= vs;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      j_q      <= j;
      cool_q   <= cool_d;
      ptr_q    <= ptr_d;
      slot_q   <= slot_d;
      jcnt_q   <= jcnt_d;
      acnt_q   <= acnt_d;
      launch_q <= launch_d;
      drop_q   <= drop_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        life_q[i]  <= life_d[i];
      end
    end
  end

  always_comb begin
    withhold_shots = '0;
    for (int i = 0; i < NUM_SLOTS; i++) withhold_shots[i] = (state_q[i] == S_IDLE);
  end

  assign launch_pulse = launch_q;
  assign launch_slot  = slot_q;
  assign fire_dropped = drop_q;
  assign j_counter    = jcnt_q;
  assign active_count = acnt_q;

endmodule

// File: tb/tb_shot_slot_scheduler.sv
// Directed bench for shot_slot_scheduler: launch, cooldown, lifetime, hit/grant collision,
// counter wrap, ship_alive gating and mid-run reset; autofire rotation when SHOT_AUTOFIRE_EN is set.
module tb_shot_slot_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_h, vs, j, ship_alive;
  logic [3:0] hit_clear;
  logic [3:0] withhold_shots;
  logic       launch_pulse, fire_dropped;
  logic [1:0] launch_slot;
  logic [3:0] j_counter;
  logic [2:0] active_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic       c_lp, c_fd, c_lp2, c_fd2;
  logic [1:0] c_ls;
  logic [3:0] c_wh, c_jc;
  logic [2:0] c_ac;
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  shot_slot_scheduler dut (
    .Clk(Clk), .Reset_h(Reset_h), .vs(vs), .j(j), .ship_alive(ship_alive),
    .hit_clear(hit_clear), .withhold_shots(withhold_shots), .launch_pulse(launch_pulse),
    .launch_slot(launch_slot), .fire_dropped(fire_dropped), .j_counter(j_counter),
    .active_count(active_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    if (launch_pulse) got_q.push_back(launch_slot);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      vs = 1'b0;
      repeat (4) cyc();
      vs = 1'b1;
      repeat (4) cyc();
    end
  endtask

  task automatic snap();
    c_lp = launch_pulse;
    c_ls = launch_slot;
    c_fd = fire_dropped;
    c_wh = withhold_shots;
    c_jc = j_counter;
    c_ac = active_count;
  endtask

  task automatic press();
    j = 1'b1;
    cyc();
    snap();
    j = 1'b0;
    cyc();
    c_lp2 = launch_pulse;
    c_fd2 = fire_dropped;
  endtask

  task automatic do_reset();
    Reset_h   = 1'b1;
    j         = 1'b0;
    hit_clear = 4'h0;
    repeat (3) cyc();
    Reset_h = 1'b0;
    cyc();
  endtask

  initial begin
    vs = 1'b1; ship_alive = 1'b1;
    do_reset();
    check("rst_wh", withhold_shots, 4'hF);
    check("rst_lp", launch_pulse, 0);
    check("rst_fd", fire_dropped, 0);
    check("rst_ls", launch_slot, 0);
    check("rst_jc", j_counter, 0);
    check("rst_ac", active_count, 0);

`ifndef SHOT_AUTOFIRE_EN
    // First launch goes to slot 0 and is a single-cycle pulse.
    press();
    check("l1_lp", c_lp, 1); check("l1_ls", c_ls, 0); check("l1_wh", c_wh, 4'b1110);
    check("l1_jc", c_jc, 1); check("l1_ac", c_ac, 1); check("l1_lp_end", c_lp2, 0);

    // Cooldown still running after two frames.
    frames(2);
    press();
    check("cd_fd", c_fd, 1); check("cd_lp", c_lp, 0); check("cd_jc", c_jc, 1);
    check("cd_wh", c_wh, 4'b1110); check("cd_fd_end", c_fd2, 0);

    frames(6);
    press();
    check("l2_lp", c_lp, 1); check("l2_ls", c_ls, 1); check("l2_wh", c_wh, 4'b1100);
    check("l2_jc", c_jc, 2); check("l2_ac", c_ac, 2);

    // Lifetime: slot 0 retires on the cycle after the 48th frame tick.
    do_reset();
    press();
    check("life_launch", c_wh, 4'b1110);
    frames(47);
    check("life_47", withhold_shots[0], 0);
    vs = 1'b0;
    cyc(); cyc();
    check("life_tick48", withhold_shots[0], 0);
    cyc();
    check("life_retire", withhold_shots[0], 1);
    check("life_ac", active_count, 0);
    vs = 1'b1;
    repeat (4) cyc();

    // Fill all four slots, then hit slot 2 on the same cycle as a press.
    do_reset();
    press(); frames(8); press(); frames(8); press(); frames(8); press();
    check("full_wh", c_wh, 4'h0); check("full_ac", c_ac, 4); check("full_ls", c_ls, 3);
    frames(8);
    j = 1'b1; hit_clear = 4'b0100;
    cyc();
    snap();
    j = 1'b0; hit_clear = 4'h0;
    cyc();
    check("hit_fd", c_fd, 1); check("hit_lp", c_lp, 0);
    check("hit_wh", c_wh, 4'b0100); check("hit_ac", c_ac, 3);
    press();
    check("rehit_lp", c_lp, 1); check("rehit_ls", c_ls, 2);
    check("rehit_wh", c_wh, 4'h0); check("rehit_jc", c_jc, 5);

    // Twelve more launches with all slots cleared: rotation continues from 3, counter wraps.
    for (int k = 0; k < 12; k++) begin
      hit_clear = 4'hF;
      cyc();
      hit_clear = 4'h0;
      frames(8);
      press();
      check("rr_lp", c_lp, 1);
      check("rr_ls", c_ls, (3 + k) % 4);
      check("rr_jc", c_jc, (6 + k) % 16);
    end
    check("wrap_jc", j_counter, 1);

    // Dead ship: press rejected, counter unchanged.
    hit_clear = 4'hF; cyc(); hit_clear = 4'h0;
    frames(8);
    ship_alive = 1'b0;
    press();
    check("dead_fd", c_fd, 1); check("dead_lp", c_lp, 0);
    check("dead_jc", c_jc, 1); check("dead_wh", c_wh, 4'hF);
    ship_alive = 1'b1;

    // Reset with three active slots and a grantable press on the same edge.
    do_reset();
    press(); frames(8); press(); frames(8); press();
    check("mr_wh_pre", c_wh, 4'b1000); check("mr_ac_pre", c_ac, 3);
    frames(8);
    Reset_h = 1'b1; j = 1'b1;
    cyc();
    check("mr_wh", withhold_shots, 4'hF); check("mr_ac", active_count, 0);
    check("mr_jc", j_counter, 0); check("mr_lp", launch_pulse, 0);
    check("mr_fd", fire_dropped, 0);
    Reset_h = 1'b0; j = 1'b0;
    repeat (2) cyc();
`else
    // Held key from reset: launches at frames 0, 8, 16, 24; at frame 32 every slot is still busy.
    Reset_h = 1'b1; j = 1'b1;
    repeat (3) cyc();
    got_q.delete();
    Reset_h = 1'b0;
    for (int s = 0; s < 4; s++) exp_q.push_back(2'(s));
    cyc(); cyc();
    frames(40);
    j = 1'b0;
    repeat (4) cyc();
    check("af_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) check("af_slot", got_q.pop_front(), exp_q.pop_front());
    check("af_jc", j_counter, 4);
    check("af_wh", withhold_shots, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
